// File: rtl/tx_pkg.sv
// ============================================================================
// Module   : tx_pkg
// Purpose  : Shared types and constants for the transmit frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

    localparam int unsigned SYM_LEN_DEF = 320;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned NSYM_W      = 8;

endpackage

`default_nettype wire

// File: rtl/tx_dcnt.sv
// ============================================================================
// Module   : tx_dcnt
// Purpose  : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_dcnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tx_frame_ctrl.sv
// ============================================================================
// Module   : tx_frame_ctrl
// Purpose  : Frame sequencer between symbol source and preamble/output stage.
//            Optional starvation flag under TX_FRAME_CTRL_UNDERRUN_DET_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int unsigned SYM_LEN  = SYM_LEN_DEF,
    parameter int unsigned TAIL_LEN = 4,
    parameter int unsigned GAP_LEN  = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              START_I,
    input  logic [NSYM_W-1:0] NSYM_I,
    input  logic              ABORT_I,
    input  logic [WORD_W-1:0] DAT_I,
    input  logic              STB_I,
    output logic              ACK_O,
    output logic [WORD_W-1:0] DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic [NSYM_W-1:0] SYM_CNT_O
`ifdef TX_FRAME_CTRL_UNDERRUN_DET_EN
    ,
    output logic              UNDERRUN_O
`endif
);

    localparam int unsigned SAMP_W = $clog2(SYM_LEN);
    localparam int unsigned TAIL_W = $clog2(TAIL_LEN + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_LEN + 1);

    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);
    localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
    localparam logic [NSYM_W-1:0] SYM_ONE   = NSYM_W'(1);
    localparam logic [TAIL_W-1:0] TAIL_LOAD = TAIL_W'(TAIL_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_LEN - 1);

    tx_state_e         state_q, state_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic [NSYM_W-1:0] sym_q, sym_d;
    logic [NSYM_W-1:0] nsym_q, nsym_d;
    logic              cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tail_load, tail_zero;
    logic gap_load, gap_zero;
    logic start_acc;
    logic xfer;

    assign start_acc = (state_q == IDLE) && START_I && (NSYM_I != '0);
    assign STB_O     = STB_I && (state_q == RUN);
    assign WE_O      = STB_O;
    assign ACK_O     = ACK_I && STB_O;
    assign DAT_O     = DAT_I;
    assign xfer      = STB_O && ACK_I;

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        sym_d     = sym_q;
        nsym_d    = nsym_q;
        tail_load = 1'b0;
        gap_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    nsym_d  = NSYM_I;
                    samp_d  = '0;
                    sym_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
                        sym_d  = sym_q + SYM_ONE;
                        if (sym_d == nsym_q) begin
                            state_d = TAIL;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_ONE;
                    end
                end
                // A same-cycle transfer is still counted before leaving RUN.
                if (ABORT_I) begin
                    state_d = TAIL;
                end
                tail_load = (state_d == TAIL);
            end
            TAIL: begin
                if (tail_zero) begin
                    state_d  = GAP;
                    gap_load = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cyc_d  = (state_d == RUN) || (state_d == TAIL);
    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q == GAP) && gap_zero;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            samp_q  <= '0;
            sym_q   <= '0;
            nsym_q  <= '0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            sym_q   <= sym_d;
            nsym_q  <= nsym_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tx_dcnt #(.WIDTH(TAIL_W)) u_tail_cnt (
        .clk_i      (CLK_I),
        .rst_ni     (RST_I),
        .load_i     (tail_load),
        .load_val_i (TAIL_LOAD),
        .dec_i      (state_q == TAIL),
        .zero_o     (tail_zero)
    );

    tx_dcnt #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk_i      (CLK_I),
        .rst_ni     (RST_I),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (state_q == GAP),
        .zero_o     (gap_zero)
    );

    assign CYC_O     = cyc_q;
    assign BUSY_O    = busy_q;
    assign DONE_O    = done_q;
    assign SYM_CNT_O = sym_q;

`ifdef TX_FRAME_CTRL_UNDERRUN_DET_EN
    logic underrun_q, underrun_d;

    // Starved: downstream ready but source idle after the frame has begun.
    always_comb begin
        underrun_d = underrun_q;
        if (start_acc) begin
            underrun_d = 1'b0;
        end else if ((state_q == RUN) && ((samp_q != '0) || (sym_q != '0))
                     && !STB_I && ACK_I) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign UNDERRUN_O = underrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_ctrl.sv
// ============================================================================
// Module   : tb_tx_frame_ctrl
// Purpose  : Self-checking bench for tx_frame_ctrl (timestamp-based model).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tx_frame_ctrl;

    localparam int SYM_LEN  = 320;
    localparam int TAIL_LEN = 4;
    localparam int GAP_LEN  = 16;

    logic        CLK_I   = 1'b0;
    logic        RST_I   = 1'b0;
    logic        START_I = 1'b0;
    logic [7:0]  NSYM_I  = 8'd0;
    logic        ABORT_I = 1'b0;
    logic [31:0] DAT_I   = 32'd0;
    logic        STB_I   = 1'b0;
    logic        ACK_I   = 1'b0;
    logic        ACK_O, CYC_O, STB_O, WE_O, BUSY_O, DONE_O;
    logic [31:0] DAT_O;
    logic [7:0]  SYM_CNT_O;
`ifdef TX_FRAME_CTRL_UNDERRUN_DET_EN
    logic        UNDERRUN_O;
`endif

    tx_frame_ctrl dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .START_I   (START_I),
        .NSYM_I    (NSYM_I),
        .ABORT_I   (ABORT_I),
        .DAT_I     (DAT_I),
        .STB_I     (STB_I),
        .ACK_O     (ACK_O),
        .DAT_O     (DAT_O),
        .CYC_O     (CYC_O),
        .STB_O     (STB_O),
        .WE_O      (WE_O),
        .ACK_I     (ACK_I),
        .BUSY_O    (BUSY_O),
        .DONE_O    (DONE_O),
        .SYM_CNT_O (SYM_CNT_O)
`ifdef TX_FRAME_CTRL_UNDERRUN_DET_EN
        ,
        .UNDERRUN_O(UNDERRUN_O)
`endif
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {lo ^ 16'hA5A5, lo};
    endfunction

    // ---------------- source / sink driver ----------------
    int src_idx   = 0;
    int ack_delay = 10;
    bit ack_rand  = 1'b0;
    bit stb_rand  = 1'b0;
    bit stb_off   = 1'b0;

    initial begin : drv
        bit took;
        bit cyc_seen;
        int pre;
        pre = 0;
        forever begin
            @(negedge CLK_I);
            took     = ACK_O;
            cyc_seen = CYC_O;
            @(posedge CLK_I);
            #1;
            if (took) src_idx++;
            if (!cyc_seen) pre = ack_delay;
            else if (pre > 0) pre--;
            ACK_I = cyc_seen && (pre == 0) && (!ack_rand || ($urandom_range(0, 2) != 0));
            STB_I = !stb_off && (!stb_rand || ($urandom_range(0, 3) != 0));
            DAT_I = word(src_idx);
        end
    end

    // ---------------- model: frame timeline by edge timestamps ----------------
    int n_edge   = 0;
    bit m_active = 1'b0;
    bit m_post   = 1'b0;
    bit m_fin;
    int m_end    = 0;
    int m_nsym   = 0;
    int m_acc    = 0;
    int m_sym    = 0;

    always @(posedge CLK_I) begin
        n_edge++;
        if (m_post && ((n_edge - 1 - m_end) >= TAIL_LEN + GAP_LEN)) m_post = 1'b0;
        if (!RST_I) begin
            m_active = 1'b0;
            m_post   = 1'b0;
            m_sym    = 0;
        end else if (m_active) begin
            m_fin = ABORT_I;
            if (STB_I && ACK_I) begin
                m_acc++;
                if (m_acc % SYM_LEN == 0) m_sym++;
                if (m_sym == m_nsym) m_fin = 1'b1;
            end
            if (m_fin) begin
                m_active = 1'b0;
                m_post   = 1'b1;
                m_end    = n_edge;
            end
        end else if (!m_post && START_I && (NSYM_I != 8'd0)) begin
            m_active = 1'b1;
            m_nsym   = int'(NSYM_I);
            m_sym    = 0;
            m_acc    = 0;
        end
    end

    // ---------------- compare + monitor ----------------
    int n_ack = 0, n_done = 0, last_ack = 0, last_cyc = 0, done_at = 0;
    logic [31:0] rx[$];

    always @(negedge CLK_I) begin
        int d;
        bit e_cyc, e_busy, e_done;
        d      = n_edge - m_end;
        e_cyc  = m_active || (m_post && d < TAIL_LEN);
        e_busy = m_active || (m_post && d < TAIL_LEN + GAP_LEN);
        e_done = m_post && (d == TAIL_LEN + GAP_LEN);
        chk("cyc_o",     CYC_O,     e_cyc);
        chk("busy_o",    BUSY_O,    e_busy);
        chk("done_o",    DONE_O,    e_done);
        chk("sym_cnt_o", SYM_CNT_O, m_sym);
        chk("stb_o",     STB_O,     m_active && STB_I);
        chk("we_o",      WE_O,      m_active && STB_I);
        chk("ack_o",     ACK_O,     m_active && STB_I && ACK_I);
        chk("dat_o",     DAT_O,     DAT_I);
        if (ACK_O === 1'b1) begin
            n_ack++;
            rx.push_back(DAT_O);
            last_ack = n_edge;
        end
        if (CYC_O === 1'b1) last_cyc = n_edge;
        if (DONE_O === 1'b1) begin
            n_done++;
            done_at = n_edge;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_stats();
        n_ack  = 0;
        n_done = 0;
        rx.delete();
    endtask

    task automatic pulse_start(input int n);
        @(posedge CLK_I);
        #1;
        NSYM_I  = n[7:0];
        START_I = 1'b1;
        @(posedge CLK_I);
        #1;
        START_I = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        int start;
        k     = 0;
        start = n_done;
        while (n_done == start && k < budget) begin
            @(posedge CLK_I);
            k++;
        end
        checks++;
        if (n_done == start) begin
            errors++;
            $display("FAIL done_wait: no DONE_O within %0d cycles", budget);
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k;
        k = 0;
        while (n_ack < n && k < budget) begin
            @(posedge CLK_I);
            k++;
        end
        checks++;
        if (n_ack < n) begin
            errors++;
            $display("FAIL ack_wait: got %0d acks required %0d", n_ack, n);
        end
    endtask

    task automatic check_rx(input string name, input int base, input int n);
        int bad;
        bad = 0;
        chk({name, "_count"}, rx.size(), n);
        for (int i = 0; i < rx.size(); i++) begin
            if (rx[i] !== word(base + i)) bad++;
        end
        chk({name, "_order"}, bad, 0);
    endtask

    int base;

    initial begin
        RST_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1 RST_I = 1'b1;
        @(negedge CLK_I);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_done", DONE_O, 0);
        chk("rst_sym", SYM_CNT_O, 0);

        // NSYM=0 request is ignored
        clear_stats();
        pulse_start(0);
        repeat (5) @(posedge CLK_I);
        @(negedge CLK_I);
        chk("nsym0_cyc", CYC_O, 0);
        chk("nsym0_busy", BUSY_O, 0);

        // Nominal two-symbol frame with long preamble; second START ignored
        ack_delay = 576;
        clear_stats();
        base = src_idx;
        pulse_start(2);
        repeat (100) @(posedge CLK_I);
        pulse_start(3);
        wait_done(3000);
        chk("nom_acks", n_ack, 640);
        chk("nom_sym", SYM_CNT_O, 2);
        chk("nom_tail", last_cyc - last_ack, 4);
        chk("nom_gap", done_at - last_cyc - 1, 16);
        check_rx("nom_rx", base, 640);
        repeat (30) @(posedge CLK_I);
        chk("nom_one_frame", n_done, 1);
        chk("nom_idle_cyc", CYC_O, 0);

        // Backpressure and starvation, one symbol
        ack_delay = 10;
        ack_rand  = 1'b1;
        stb_rand  = 1'b1;
        clear_stats();
        base = src_idx;
        pulse_start(1);
        wait_done(5000);
        ack_rand = 1'b0;
        stb_rand = 1'b0;
        chk("bp_acks", n_ack, 320);
        chk("bp_sym", SYM_CNT_O, 1);
        check_rx("bp_rx", base, 320);

        // Abort on transfer 100 of symbol 1 with same-cycle accept
        clear_stats();
        base = src_idx;
        pulse_start(3);
        wait_acks(420, 2000);
        #1 ABORT_I = 1'b1;
        @(posedge CLK_I);
        #1 ABORT_I = 1'b0;
        wait_done(200);
        chk("abort_acks", n_ack, 421);
        chk("abort_sym", SYM_CNT_O, 1);
        chk("abort_tail", last_cyc - last_ack, 4);
        chk("abort_gap", done_at - last_cyc - 1, 16);
        check_rx("abort_rx", base, 421);

        // Reset during RUN at transfer 50
        clear_stats();
        pulse_start(2);
        wait_acks(50, 1000);
        #1 RST_I = 1'b0;
        @(posedge CLK_I);
        #1 RST_I = 1'b1;
        @(negedge CLK_I);
        chk("rstrun_cyc", CYC_O, 0);
        chk("rstrun_busy", BUSY_O, 0);
        chk("rstrun_sym", SYM_CNT_O, 0);
        repeat (40) @(posedge CLK_I);
        chk("rstrun_nodone", n_done, 0);

`ifdef TX_FRAME_CTRL_UNDERRUN_DET_EN
        clear_stats();
        pulse_start(1);
        wait_acks(30, 1000);
        #2 stb_off = 1'b1;
        repeat (3) @(posedge CLK_I);
        #2 stb_off = 1'b0;
        @(negedge CLK_I);
        chk("udr_set", UNDERRUN_O, 1);
        wait_done(1000);
        chk("udr_sticky", UNDERRUN_O, 1);
        pulse_start(1);
        @(negedge CLK_I);
        chk("udr_clear", UNDERRUN_O, 0);
        wait_done(1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
